// File: rtl/alu_seq_datapath.sv
// Sequenced accumulator datapath: register file, ALU, post-ALU shifter and PSW; optional saturation under ALU_SAT_EN.
// Latency: accept in cycle 0, LOAD 1, EXEC 2, WB 3 (res_valid pulse); next accept possible in cycle 4.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, not queued.
module alu_seq_datapath #(
    parameter int DATAWIDTH  = 8,
    parameter int REGCOUNT   = 4,
    parameter int INDEXWIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_alu_op,
    input  logic [1:0]            cmd_st_op,
    input  logic [INDEXWIDTH-1:0] cmd_ra,
    input  logic [INDEXWIDTH-1:0] cmd_rb,
    input  logic [INDEXWIDTH-1:0] cmd_rd,
    input  logic [DATAWIDTH-1:0]  cmd_imm,
    input  logic                  cmd_use_imm,
    input  logic                  cmd_psw_we,
    output logic [DATAWIDTH-1:0]  res_data,
    output logic                  res_valid,
    output logic [3:0]            psw,
    output logic                  busy
);

    localparam int MSB = DATAWIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    localparam logic [1:0] SH_SHL = 2'd1;
    localparam logic [1:0] SH_SHR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_WB} state_t;

    state_t state_q, state_d;

    logic [2:0]            op_q;
    logic [1:0]            st_q;
    logic [INDEXWIDTH-1:0] ra_q, rb_q, rd_q;
    logic [DATAWIDTH-1:0]  imm_q;
    logic                  use_imm_q;
    logic                  psw_we_q;

    logic [DATAWIDTH-1:0]  rf [REGCOUNT];
    logic [DATAWIDTH-1:0]  a_q, b_q, s_q, res_q;
    logic [3:0]            psw_q;

    logic                  accept;
    logic [DATAWIDTH:0]    a_ext, b_ext, c_ext, sum_ext, dif_ext;
    logic [DATAWIDTH-1:0]  alu_f, sh_f;
    logic                  alu_c, alu_v, sh_c;
    logic [3:0]            psw_nxt;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = (state_q == ST_IDLE) && RESET_N;
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_WB);
    assign res_data  = res_q;
    assign psw       = psw_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One extra bit holds carry-out (add) or borrow (subtract); carry-in comes from the held PSW.C.
    assign a_ext   = {1'b0, a_q};
    assign b_ext   = {1'b0, b_q};
    assign c_ext   = {{DATAWIDTH{1'b0}}, psw_q[0]};
    assign sum_ext = a_ext + b_ext + ((op_q == OP_ADC) ? c_ext : '0);
    assign dif_ext = a_ext - b_ext - ((op_q == OP_SBB) ? c_ext : '0);

    always_comb begin
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                alu_f = sum_ext[MSB:0];
                alu_c = sum_ext[DATAWIDTH];
                alu_v = (a_q[MSB] == b_q[MSB]) && (alu_f[MSB] != a_q[MSB]);
`ifdef ALU_SAT_EN
                if (alu_c) begin
                    alu_f = '1;
                    alu_v = 1'b0;
                end
`endif
            end
            OP_SUB, OP_SBB: begin
                alu_f = dif_ext[MSB:0];
                alu_c = dif_ext[DATAWIDTH];
                alu_v = (a_q[MSB] != b_q[MSB]) && (alu_f[MSB] != a_q[MSB]);
`ifdef ALU_SAT_EN
                if (alu_c) begin
                    alu_f = '0;
                    alu_v = 1'b0;
                end
`endif
            end
            OP_AND:  alu_f = a_q & b_q;
            OP_OR:   alu_f = a_q | b_q;
            OP_XOR:  alu_f = a_q ^ b_q;
            default: alu_f = b_q;
        endcase
    end

    always_comb begin
        sh_f = alu_f;
        sh_c = alu_c;
        case (st_q)
            SH_SHL: begin
                sh_f = {alu_f[MSB-1:0], 1'b0};
                sh_c = alu_f[MSB];
            end
            SH_SHR: begin
                sh_f = {1'b0, alu_f[MSB:1]};
                sh_c = alu_f[0];
            end
            SH_ROR: begin
                sh_f = {alu_f[0], alu_f[MSB:1]};
                sh_c = alu_f[0];
            end
            default: ;
        endcase
    end

    // V always comes from the ALU; N and Z from the final shifted value.
    assign psw_nxt = {alu_v, sh_f[MSB], (sh_f == '0), sh_c};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q      <= '0;
            st_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            psw_we_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            res_q     <= '0;
            psw_q     <= '0;
            for (int i = 0; i < REGCOUNT; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q      <= cmd_alu_op;
                st_q      <= cmd_st_op;
                ra_q      <= cmd_ra;
                rb_q      <= cmd_rb;
                rd_q      <= cmd_rd;
                imm_q     <= cmd_imm;
                use_imm_q <= cmd_use_imm;
                psw_we_q  <= cmd_psw_we;
            end
            case (state_q)
                ST_LOAD: begin
                    a_q <= rf[ra_q];
                    b_q <= use_imm_q ? imm_q : rf[rb_q];
                end
                ST_EXEC: begin
                    // res_data changes together with S so the WB-cycle pulse carries the new value.
                    s_q   <= sh_f;
                    res_q <= sh_f;
                    if (psw_we_q) psw_q <= psw_nxt;
                end
                ST_WB: rf[rd_q] <= s_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_datapath.sv
// Directed bench for alu_seq_datapath (DATAWIDTH=4): integer-level model plus scoreboard checked every cycle,
// with hand-computed literals for the key vectors; build with ALU_SAT_EN defined for the saturating variant.
module tb_alu_seq_datapath;

    localparam int DW = 4;
    localparam int M  = 16;
    localparam int H  = 8;

    logic       CLK;
    logic       RESET_N;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_alu_op;
    logic [1:0] cmd_st_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic [3:0] cmd_imm;
    logic       cmd_use_imm;
    logic       cmd_psw_we;
    logic [3:0] res_data;
    logic       res_valid;
    logic [3:0] psw;
    logic       busy;

    alu_seq_datapath #(.DATAWIDTH(DW), .REGCOUNT(4), .INDEXWIDTH(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_alu_op(cmd_alu_op), .cmd_st_op(cmd_st_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm), .cmd_psw_we(cmd_psw_we),
        .res_data(res_data), .res_valid(res_valid), .psw(psw), .busy(busy)
    );

    typedef struct {
        int res;
        int psw;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int   mr[4];
    int   mpsw;
    int   cyc;
    int   last_res;
    int   last_psw;
    int   n_pass;
    int   n_total;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    function automatic int sgn(input int x);
        return (x >= H) ? x - M : x;
    endfunction

    // Integer model: result and {V,N,Z,C} from the operation's arithmetic definition.
    task automatic model_op(input int op, input int st, input int a, input int b, input int cin,
                            output int f, output int p);
        int r, sr, c, v, n, z, ci;
        c = 0; v = 0; f = 0;
        ci = (op == 1 || op == 3) ? cin : 0;
        case (op)
            0, 1: begin
                r  = a + b + ci;
                sr = sgn(a) + sgn(b) + ci;
                c  = (r >= M) ? 1 : 0;
                v  = (sr >= H || sr < -H) ? 1 : 0;
                f  = r % M;
`ifdef ALU_SAT_EN
                if (c == 1) begin f = M - 1; v = 0; end
`endif
            end
            2, 3: begin
                r  = a - b - ci;
                sr = sgn(a) - sgn(b) - ci;
                c  = (r < 0) ? 1 : 0;
                v  = (sr >= H || sr < -H) ? 1 : 0;
                f  = (r + M) % M;
`ifdef ALU_SAT_EN
                if (c == 1) begin f = 0; v = 0; end
`endif
            end
            4: f = a & b;
            5: f = a | b;
            6: f = a ^ b;
            default: f = b;
        endcase
        case (st)
            1: begin c = f / H; f = (f * 2) % M; end
            2: begin c = f % 2; f = f / 2; end
            3: begin c = f % 2; f = f / 2 + c * H; end
            default: ;
        endcase
        n = (f >= H) ? 1 : 0;
        z = (f == 0) ? 1 : 0;
        p = v * 8 + n * 4 + z * 2 + c;
    endtask

    // Called at a falling edge while idle; returns at the falling edge of LOAD with cmd_valid low.
    task automatic issue(input int op, input int st, input int ra, input int rb, input int rd,
                         input int imm, input int use_imm, input int we);
        int   n, a, b, f, p;
        exp_t e;
        cmd_alu_op  = op[2:0];
        cmd_st_op   = st[1:0];
        cmd_ra      = ra[1:0];
        cmd_rb      = rb[1:0];
        cmd_rd      = rd[1:0];
        cmd_imm     = imm[3:0];
        cmd_use_imm = use_imm[0];
        cmd_psw_we  = we[0];
        cmd_valid   = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        a = mr[ra];
        b = (use_imm != 0) ? imm : mr[rb];
        model_op(op, st, a, b, mpsw % 2, f, p);
        if (we != 0) mpsw = p;
        mr[rd] = f;
        e.res = f;
        e.psw = mpsw;
        e.cyc = cyc + 3;
        q.push_back(e);
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    task automatic run(input int op, input int st, input int ra, input int rb, input int rd,
                       input int imm, input int use_imm, input int we);
        issue(op, st, ra, rb, rd, imm, use_imm, we);
        wait_idle();
    endtask

    task automatic readback(input int i, input int expv);
        run(7, 0, 0, i, i, 0, 0, 0);
        chk("readback", res_data, expv);
    endtask

    // Scoreboard: every cycle out of reset checks handshake/busy timing, WB pulse and held outputs.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            last_res = 0;
            last_psw = 0;
        end else begin
            int bexp;
            bexp = (q.size() > 0 && cyc >= q[0].cyc - 2) ? 1 : 0;
            chk("busy", busy, bexp);
            chk("cmd_ready", cmd_ready, 1 - bexp);
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_res_valid", 1, 0);
                end else begin
                    ce = q.pop_front();
                    chk("wb_cycle", cyc, ce.cyc);
                    chk("res_data", res_data, ce.res);
                    chk("psw", psw, ce.psw);
                    last_res = ce.res;
                    last_psw = ce.psw;
                end
            end else begin
                if (q.size() > 0 && cyc > q[0].cyc) begin
                    chk("res_valid_missing", 0, 1);
                    void'(q.pop_front());
                end
                chk("res_hold", res_data, last_res);
                chk("psw_hold", psw, last_psw);
            end
        end
    end

    initial begin
        n_pass = 0; n_total = 0; mpsw = 0;
        last_res = 0; last_psw = 0;
        for (int i = 0; i < 4; i++) mr[i] = 0;
        RESET_N = 1'b0; cmd_valid = 1'b0;
        cmd_alu_op = '0; cmd_st_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        cmd_imm = '0; cmd_use_imm = 1'b0; cmd_psw_we = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_psw", psw, 0);
        #2 RESET_N = 1'b1;
        #1 chk("rst_ready", cmd_ready, 1);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) readback(i, 0);

        // PASS imm=5 into R1
        run(7, 0, 0, 0, 1, 5, 1, 1);
        chk("pass5_res", res_data, 5);  chk("pass5_psw", psw, 4'b0000);
        // ADD 5 + 0xB
        run(0, 0, 1, 0, 3, 11, 1, 1);
`ifdef ALU_SAT_EN
        chk("add_res", res_data, 15);   chk("add_psw", psw, 4'b0101);
`else
        chk("add_res", res_data, 0);    chk("add_psw", psw, 4'b0011);
`endif
        run(7, 0, 0, 0, 2, 3, 1, 1);
        // SUB 3 - 5
        run(2, 0, 2, 0, 0, 5, 1, 1);
`ifdef ALU_SAT_EN
        chk("sub_res", res_data, 0);    chk("sub_psw", psw, 4'b0011);
`else
        chk("sub_res", res_data, 14);   chk("sub_psw", psw, 4'b0101);
`endif
        // ADC 3 + 0 + C
        run(1, 0, 2, 0, 0, 0, 1, 1);
        chk("adc_res", res_data, 4);    chk("adc_psw", psw, 4'b0000);
        // PASS 0x9 then SHL
        run(7, 1, 0, 0, 0, 9, 1, 1);
        chk("shl_res", res_data, 2);    chk("shl_psw", psw, 4'b0001);
        // PASS 0x1 then ROR
        run(7, 3, 0, 0, 0, 1, 1, 1);
        chk("ror_res", res_data, 8);    chk("ror_psw", psw, 4'b0101);
        // psw_we=0 keeps the previous flags
        run(7, 0, 0, 0, 0, 0, 1, 0);
        chk("nowe_res", res_data, 0);   chk("nowe_psw", psw, 4'b0101);
        // signed overflow 7 + 1
        run(7, 0, 0, 0, 2, 7, 1, 1);
        run(0, 0, 2, 0, 2, 1, 1, 1);
        chk("ovf_res", res_data, 8);    chk("ovf_psw", psw, 4'b1100);

        // register-sourced operands, aliasing and remaining ops (model-checked)
        run(6, 0, 1, 1, 1, 0, 0, 1);
        run(2, 0, 2, 3, 0, 0, 0, 1);
        run(3, 0, 2, 2, 2, 0, 0, 1);
        run(5, 2, 3, 0, 3, 6, 1, 1);
        run(4, 2, 3, 2, 1, 0, 0, 1);
        run(0, 1, 2, 2, 2, 0, 0, 1);
        run(3, 3, 0, 1, 0, 3, 1, 1);
        for (int i = 0; i < 4; i++) readback(i, mr[i]);

        // fields toggling with cmd_valid held high while busy must be ignored
        issue(7, 0, 0, 0, 3, 6, 1, 1);
        cmd_valid = 1'b1; cmd_alu_op = 3'd0; cmd_rd = 2'd0; cmd_imm = 4'hF;
        @(negedge CLK);
        cmd_alu_op = 3'd6; cmd_rd = 2'd1; cmd_imm = 4'h3;
        @(negedge CLK);
        cmd_valid = 1'b0;
        wait_idle();
        chk("hold_res", res_data, 6);
        readback(0, mr[0]);
        readback(1, mr[1]);

        // reset during EXEC aborts the command
        issue(0, 0, 3, 0, 3, 1, 1, 1);
        @(negedge CLK);
        RESET_N = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) mr[i] = 0;
        mpsw = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_psw", psw, 0);
        repeat (2) @(negedge CLK);
        chk("abort_no_pulse", res_valid, 0);
        #2 RESET_N = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) readback(i, 0);

        repeat (3) @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
